debounce_filter_mc: RTL and testbench
=====================================

# debounce_filter_mc

Multi-channel, parametrised debounce/glitch filter for slow external inputs such as buttons, limit switches and jumpers. It is the next-generation replacement for the single-channel fixed-30-cycle filter. Each channel accepts a new input level only after that level has been held for THRESH consecutive qualified samples. Each channel drives:
- a filtered level, with optionally inverted polarity;
- one-cycle rise/fall strobes for downstream FSMs and counters.

## Interface
Parameters:
- CH, 4: number of independent channels (≥1).
- CNT_W, 5: stability-counter width per channel.
- THRESH, 30: consecutive differing samples required to accept a new level; legal range 1 .. 2^CNT_W−1.
- INVERT, 1: 1 → q is the complement of the filtered level (legacy behaviour); 0 → q equals the filtered level.
- RESET_VAL, 0: filtered level loaded into every channel at reset.

Ports:
- clk, input, 1: single clock; all state is updated on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ce, input, 1: sample qualifier. When ce=0, all state holds, except that rise/fall still clear.
- d, input, CH: raw inputs, one bit per channel.
- q, output, CH: filtered level XOR INVERT.
- rise, output, CH: one-cycle strobe; the filtered level went 0→1 (strobes are not affected by INVERT).
- fall, output, CH: one-cycle strobe; the filtered level went 1→0.

## Operation
- Per-channel state: filtered level st[i], counter cnt[i] (CNT_W bits), and sample s[i]. s[i] is the raw d[i], or the synchronised d[i] when synchronisation is compiled in (see Configuration).
- Reset (rst_n=0, asynchronous):
  - st = RESET_VAL, cnt = 0, rise = fall = 0, sync flops = RESET_VAL.
  - Resulting output: q = RESET_VAL ^ INVERT, so with the defaults q resets to all-ones.
- On each clk edge with ce=1, each channel evaluates independently:
  - s == st → cnt ← 0 (any agreeing sample restarts qualification).
  - s != st and cnt < THRESH−1 → cnt ← cnt+1.
  - s != st and cnt == THRESH−1 → st ← s, cnt ← 0, and rise[i] (if s=1) or fall[i] (if s=0) is set for exactly one cycle.
- rise/fall are cleared on every edge on which they are not being set, regardless of ce.
- For any channel, rise and fall are never both 1 in the same cycle.
- THRESH=1: the first differing qualified sample is accepted.
- The counter never exceeds THRESH−1, so there is no wrap-around.
- Glitch rejection: a pulse shorter than THRESH qualified samples never changes st. A single agreeing sample mid-run restarts the count from 0.
- Channels share ce and clk only; there is no cross-channel interaction.
- Reset asserted mid-qualification discards partial counts immediately. No strobe is produced.

## Timing
- Without synchronisation: after d[i] changes and stays stable, st/q update on the THRESH-th qualified edge that samples the new value. rise/fall are asserted in the same cycle as the st change.
- With synchronisation: latency increases by 2 clk edges.
- If ce is toggling, latency is counted in qualified edges (ce=1), not clk edges.
- q is registered: there is no combinational path from d to q, rise or fall.

## Configuration
- DEBOUNCE_SYNC_EN defined:
  - Each d[i] passes through a 2-flop synchroniser, clocked every clk edge regardless of ce.
  - The synchroniser is reset to RESET_VAL.
  - s is taken from the second flop.
- DEBOUNCE_SYNC_EN undefined:
  - s = d directly; the caller guarantees d is already synchronous to clk.
  - No extra latency.

## Test plan
All scenarios use CH=4, THRESH=30, INVERT=1, RESET_VAL=0, no sync, ce=1 unless stated.
- Reset: assert rst_n=0 asynchronously mid-cycle → q=4'b1111 and rise=fall=0 immediately. Release, hold d=0 for 100 cycles → q stays 4'b1111, no strobes.
- Accept: d[0] 0→1 and held → q[0] falls to 0 after exactly the 30th edge. rise[0]=1 for one cycle, simultaneous with the q change. Other channels are unchanged.
- Glitch: d[1]=1 for 29 cycles then 0 → q[1] stays 1 and there is no strobe. Then d[1]=1 for 29 cycles, 0 for 1 cycle, 1 for 30 cycles → q[1] changes only at the end of the 30-cycle run.
- ce gating: ce high one cycle in three, d[2] 0→1 → q[2] changes after 30 qualified edges (about 90 clk edges). rise[2] is a single clk-cycle pulse.
- Independent/simultaneous: d[3:0]=4'b1010 at once → q=4'b0101 and rise=4'b1010 on the same edge. Then d=4'b0000 → fall=4'b1010 exactly 30 edges later.
- Edge parameters and sync: rebuild with THRESH=1, INVERT=0 → q follows d with 1 edge of latency. Rebuild with DEBOUNCE_SYNC_EN defined → latency is THRESH+2 edges, and reset mid-count (at count 15) followed by release requires a full 30 again.

Source files
------------

// File: rtl/debounce_filter_mc_if.sv
// debounce_filter_mc_if
// Bundles the sample qualifier, the raw inputs and the filtered outputs of
// debounce_filter_mc.
//   ce   : sample qualifier (master -> slave)
//   d    : raw inputs, one bit per channel (master -> slave)
//   q    : filtered level, polarity set by the filter's INVERT (slave -> master)
//   rise : one-cycle strobe, filtered level went 0->1 (slave -> master)
//   fall : one-cycle strobe, filtered level went 1->0 (slave -> master)
interface debounce_filter_mc_if #(
  parameter int CH = 4
);
  logic          ce;
  logic [CH-1:0] d;
  logic [CH-1:0] q;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (output ce, output d, input q, input rise, input fall);
  modport slave  (input ce, input d, output q, output rise, output fall);
endinterface

// File: rtl/debounce_filter_mc.sv
// debounce_filter_mc
// Multi-channel debounce / glitch filter for slow external inputs. A channel
// adopts a new level only after it has been sampled THRESH consecutive
// qualified times (ce=1). Each acceptance emits a one-cycle rise or fall strobe
// in the same cycle the filtered level changes.
//
// Optional feature: define DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in
// front of every channel (adds 2 clk edges of latency, runs regardless of ce).
//
// Ports:
//   clk   : clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : debounce_filter_mc_if slave (ce, d in; q, rise, fall out)
module debounce_filter_mc #(
  parameter int CH        = 4,
  parameter int CNT_W     = 5,
  parameter int THRESH    = 30,
  parameter int INVERT    = 1,
  parameter int RESET_VAL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debounce_filter_mc_if.slave  bus
);

  localparam logic             RST_LVL = (RESET_VAL != 0);
  localparam logic             INV_LVL = (INVERT != 0);
  localparam logic [CNT_W-1:0] TERM    = CNT_W'(THRESH - 1);

  logic [CH-1:0]    s;
  logic [CH-1:0]    st_q,   st_nxt;
  logic [CH-1:0]    rise_q, rise_nxt;
  logic [CH-1:0]    fall_q, fall_nxt;
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_nxt [CH];

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync_p0;
  logic [CH-1:0] sync_p1;

  // Synchroniser stages: free-running, independent of ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {CH{RST_LVL}};
      sync_p1 <= {CH{RST_LVL}};
    end else begin
      sync_p0 <= bus.d;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;
`else
  assign s = bus.d;
`endif

  // Per-channel qualification. The counter holds the number of consecutive
  // differing samples seen so far minus one boundary: reaching TERM on a
  // differing sample is the THRESH-th one, so the level is accepted there.
  // Using >= keeps the counter bounded even if it were ever corrupted.
  always_comb begin
    st_nxt   = st_q;
    cnt_nxt  = cnt_q;
    rise_nxt = '0;
    fall_nxt = '0;
    if (bus.ce) begin
      for (int i = 0; i < CH; i++) begin
        if (s[i] == st_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_q[i] >= TERM) begin
          st_nxt[i]   = s[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter state; strobes fall back to 0 on every edge that does not set them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= {CH{RST_LVL}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      st_q   <= st_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.q    = st_q ^ {CH{INV_LVL}};
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_debounce_filter_mc.sv
// tb_debounce_filter_mc
// Directed bench for debounce_filter_mc (CH=4, THRESH=30, INVERT=1,
// RESET_VAL=0). Each clock step pushes the expected {q, rise, fall} from a
// reference model onto a scoreboard and pops it after the edge; directed
// checks additionally pin edge counts for acceptance and glitch rejection.
module tb_debounce_filter_mc;

  localparam int CH     = 4;
  localparam int THRESH = 30;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  debounce_filter_mc_if #(.CH(CH)) bus ();

  debounce_filter_mc #(
    .CH(CH), .CNT_W(5), .THRESH(THRESH), .INVERT(1), .RESET_VAL(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total    = 0;
  int   pass_cnt = 0;
  exp_t sb[$];

  // reference model state
  logic [3:0] m_st;
  int         m_run [4];
  logic [3:0] m_s1, m_s2;

  // last observation
  logic [3:0] last_q, last_rise, last_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 4'b0000;
    m_s1 = 4'b0000;
    m_s2 = 4'b0000;
    for (int c = 0; c < 4; c++) m_run[c] = 0;
  endtask

  // One clock: drive, predict, wait for edge, compare.
  task automatic step(input logic ce_v, input logic [3:0] d_v);
    logic [3:0] samp;
    exp_t       e;
    exp_t       o;
    bus.ce = ce_v;
    bus.d  = d_v;
`ifdef DEBOUNCE_SYNC_EN
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = d_v;
`else
    samp = d_v;
`endif
    e.rise = 4'b0000;
    e.fall = 4'b0000;
    if (ce_v) begin
      for (int c = 0; c < 4; c++) begin
        if (samp[c] != m_st[c]) begin
          m_run[c]++;
          if (m_run[c] == THRESH) begin
            m_st[c]  = samp[c];
            m_run[c] = 0;
            if (samp[c]) e.rise[c] = 1'b1;
            else         e.fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    e.q = ~m_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = {bus.q, bus.rise, bus.fall};
    last_q    = bus.q;
    last_rise = bus.rise;
    last_fall = bus.fall;
    chk("cycle_qrf", 32'(o), 32'(sb.pop_front()));
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_q"},    32'(bus.q),    32'h0000000f);
    chk({tag, "_rise"}, 32'(bus.rise), 32'h0);
    chk({tag, "_fall"}, 32'(bus.fall), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] acc;
    int         first;
    int         nrise;
    bus.ce = 1'b0;
    bus.d  = 4'b0000;
    model_reset();

    // Power-on reset
    #1;
    rst_n = 1'b0;
    #1;
    chk("por_q",    32'(bus.q),    32'h0000000f);
    chk("por_rise", 32'(bus.rise), 32'h0);
    chk("por_fall", 32'(bus.fall), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset: d=0 for 100 cycles
    acc = 4'b0000;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 4'b0000);
      acc |= last_rise | last_fall;
    end
    chk("idle_strobes", 32'(acc),    32'h0);
    chk("idle_q",       32'(last_q), 32'h0000000f);

    // Accept on channel 0
    first = 0;
    for (int k = 1; k <= THRESH + LAT; k++) begin
      step(1'b1, 4'b0001);
      if (last_rise[0] && first == 0) first = k;
    end
    chk("accept_edge", 32'(first),     32'(THRESH + LAT));
    chk("accept_q",    32'(last_q),    32'h0000000e);
    chk("accept_rise", 32'(last_rise), 32'h1);
    // reset while the strobe is high clears it immediately
    do_reset("rst_on_strobe");

    // Glitch of 29 samples on channel 1
    acc = 4'b0000;
    for (int k = 0; k < 29; k++) begin
      step(1'b1, 4'b0010);
      acc |= last_rise | last_fall;
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0000);
      acc |= last_rise | last_fall;
    end
    chk("glitch29_strobes", 32'(acc),    32'h0);
    chk("glitch29_q",       32'(last_q), 32'h0000000f);

    // 29 high, 1 low, then a full run
    acc = 4'b0000;
    for (int k = 0; k < 29; k++) begin
      step(1'b1, 4'b0010);
      acc |= last_rise | last_fall;
    end
    step(1'b1, 4'b0000);
    acc |= last_rise | last_fall;
    first = 0;
    for (int k = 1; k <= THRESH + LAT; k++) begin
      step(1'b1, 4'b0010);
      if (last_rise[1] && first == 0) first = k;
      if (first == 0) acc |= last_rise | last_fall;
    end
    chk("restart_no_early", 32'(acc),    32'h0);
    chk("restart_edge",     32'(first),  32'(THRESH + LAT));
    chk("restart_q",        32'(last_q), 32'h0000000d);

    // ce gating: qualified one edge in three on channel 2
    do_reset("rst_ce");
    first = -1;
    nrise = 0;
    for (int k = 0; k < 120; k++) begin
      step((k % 3) == 0, 4'b0100);
      if (last_rise[2]) begin
        nrise++;
        if (first < 0) first = k;
      end
    end
    chk("ce_edge",   32'(first), 32'((LAT == 0) ? 87 : 90));
    chk("ce_pulses", 32'(nrise), 32'h1);
    chk("ce_q",      32'(last_q), 32'h0000000b);

    // Simultaneous rise then fall on channels 1 and 3
    do_reset("rst_sim");
    first = 0;
    for (int k = 1; k <= THRESH + LAT; k++) begin
      step(1'b1, 4'b1010);
      if (last_rise != 4'b0000 && first == 0) first = k;
    end
    chk("sim_rise_edge", 32'(first),     32'(THRESH + LAT));
    chk("sim_rise_val",  32'(last_rise), 32'ha);
    chk("sim_q",         32'(last_q),    32'h5);
    first = 0;
    for (int k = 1; k <= THRESH + LAT; k++) begin
      step(1'b1, 4'b0000);
      if (last_fall != 4'b0000 && first == 0) first = k;
    end
    chk("sim_fall_edge", 32'(first),     32'(THRESH + LAT));
    chk("sim_fall_val",  32'(last_fall), 32'ha);
    chk("sim_fall_q",    32'(last_q),    32'hf);

    // Reset mid-count discards the partial count
    for (int k = 0; k < 15; k++) step(1'b1, 4'b0001);
    do_reset("rst_mid");
    first = 0;
    for (int k = 1; k <= THRESH + LAT + 2; k++) begin
      step(1'b1, 4'b0001);
      if (last_rise[0] && first == 0) first = k;
    end
    chk("mid_reset_edge", 32'(first), 32'(THRESH + LAT));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
